reorder_buffer: RTL and testbench

Reorder buffer sitting between the instruction decoder/dispatcher and the architectural register file. It accepts one decoded instruction per cycle, allocates a tag equal to the current tail index, and records completion results from the common data bus. It retires entries strictly in program order: one register writeback, store release or branch resolution per cycle. On a branch or JALR misprediction it flushes the pipeline.

---
 rtl/reorder_buffer.sv | 148 ++++++++++++++
 tb/tb_reorder_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order completions, with store release
// and branch/JALR redirect. A misprediction flushes every entry at the retiring edge.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             Issue_Ready,
    input  logic [1:0]       Issue_Type,
    input  logic [31:0]      Issue_Rd,
    output logic             success,
    output logic [TAG_W-1:0] ROB_Tail,
    input  logic             CDB_Ready,
    input  logic [TAG_W-1:0] CDB_Tag,
    input  logic [31:0]      CDB_Value,
    input  logic             CDB_Jump,
    input  logic [31:0]      CDB_Target,
    input  logic [TAG_W-1:0] Query_Tag,
    output logic             Query_Done,
    output logic [31:0]      Query_Value,
    output logic             ROB_Ready,
    output logic [4:0]       ROB_Addr,
    output logic [31:0]      ROB_Value,
    output logic [TAG_W-1:0] ROB_Tag,
    output logic             Store_Commit,
    output logic [TAG_W-1:0] Store_Tag,
    output logic             clr,
    output logic [31:0]      New_PC
);

    localparam logic [1:0] TYPE_REG    = 2'b00;
    localparam logic [1:0] TYPE_STORE  = 2'b01;
    localparam logic [1:0] TYPE_BRANCH = 2'b10;
    localparam logic [1:0] TYPE_JALR   = 2'b11;

    localparam logic [TAG_W-1:0] ONE_TAG    = {{(TAG_W-1){1'b0}}, 1'b1};
    localparam logic [TAG_W:0]   ONE_CNT    = {{TAG_W{1'b0}}, 1'b1};
    localparam logic [TAG_W:0]   FULL_COUNT = {1'b1, {TAG_W{1'b0}}};

    logic [TAG_W-1:0] head_q, tail_q;
    logic [TAG_W:0]   count_q;
    logic [DEPTH-1:0] valid_q;

    logic             done_q   [DEPTH];
    logic [1:0]       type_q   [DEPTH];
    logic [4:0]       rd_q     [DEPTH];
    logic [31:0]      value_q  [DEPTH];
    logic             jump_q   [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic       commit, mispredict, flush, issue_we, cdb_we;
    logic [1:0] head_type;

    // A branch's PC bits are not needed here: the CDB supplies the resolved target.
    logic unused_pc;
    assign unused_pc = ^Issue_Rd[31:5];

    // rdy is folded into every enable so a frozen cycle changes nothing.
    assign head_type  = type_q[head_q];
    assign commit     = rdy & valid_q[head_q] & done_q[head_q];
    assign mispredict = (head_type == TYPE_BRANCH) && (rd_q[head_q][0] != jump_q[head_q]);
    assign flush      = commit & ((head_type == TYPE_JALR) | mispredict);
    assign issue_we   = rdy & Issue_Ready & success & ~flush;
    assign cdb_we     = rdy & CDB_Ready & valid_q[CDB_Tag] & ~flush;

    assign success     = (count_q != FULL_COUNT);
    assign ROB_Tail    = tail_q;
    assign Query_Done  = valid_q[Query_Tag] & done_q[Query_Tag];
    assign Query_Value = value_q[Query_Tag];

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            ROB_Ready    <= 1'b0;
            ROB_Addr     <= '0;
            ROB_Value    <= '0;
            ROB_Tag      <= '0;
            Store_Commit <= 1'b0;
            Store_Tag    <= '0;
            clr          <= 1'b0;
            New_PC       <= '0;
        end else begin
            ROB_Ready    <= 1'b0;
            Store_Commit <= 1'b0;
            clr          <= 1'b0;
            if (commit) begin
                if (head_type == TYPE_REG || head_type == TYPE_JALR) begin
                    ROB_Ready <= 1'b1;
                    ROB_Addr  <= rd_q[head_q];
                    ROB_Value <= value_q[head_q];
                    ROB_Tag   <= head_q;
                end
                if (head_type == TYPE_STORE) begin
                    Store_Commit <= 1'b1;
                    Store_Tag    <= head_q;
                end
                if (flush) begin
                    clr    <= 1'b1;
                    New_PC <= target_q[head_q];
                end
            end

            if (flush) begin
                valid_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                // Head and tail differ whenever both fire, since a full buffer refuses issue.
                if (commit) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + ONE_TAG;
                end
                if (issue_we) begin
                    valid_q[tail_q] <= 1'b1;
                    tail_q          <= tail_q + ONE_TAG;
                end
                case ({issue_we, commit})
                    2'b10:   count_q <= count_q + ONE_CNT;
                    2'b01:   count_q <= count_q - ONE_CNT;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // NOTE: the payload arrays carry no reset; every read is qualified by valid_q,
    // so stale contents are harmless and the storage can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (issue_we) begin
            type_q[tail_q] <= Issue_Type;
            rd_q[tail_q]   <= Issue_Rd[4:0];
            done_q[tail_q] <= 1'b0;
        end
        if (cdb_we) begin
            done_q[CDB_Tag]   <= 1'b1;
            value_q[CDB_Tag]  <= CDB_Value;
            jump_q[CDB_Tag]   <= CDB_Jump;
            target_q[CDB_Tag] <= CDB_Target;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a per-cycle vector table for in-order retirement,
// hand-written sequences for full/flush/JALR/store/stall, and a scoreboard of commit events.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        Issue_Ready;
    logic [1:0]  Issue_Type;
    logic [31:0] Issue_Rd;
    logic        success;
    logic [3:0]  ROB_Tail;
    logic        CDB_Ready;
    logic [3:0]  CDB_Tag;
    logic [31:0] CDB_Value;
    logic        CDB_Jump;
    logic [31:0] CDB_Target;
    logic [3:0]  Query_Tag;
    logic        Query_Done;
    logic [31:0] Query_Value;
    logic        ROB_Ready;
    logic [4:0]  ROB_Addr;
    logic [31:0] ROB_Value;
    logic [3:0]  ROB_Tag;
    logic        Store_Commit;
    logic [3:0]  Store_Tag;
    logic        clr;
    logic [31:0] New_PC;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .Issue_Ready(Issue_Ready), .Issue_Type(Issue_Type), .Issue_Rd(Issue_Rd),
        .success(success), .ROB_Tail(ROB_Tail),
        .CDB_Ready(CDB_Ready), .CDB_Tag(CDB_Tag), .CDB_Value(CDB_Value),
        .CDB_Jump(CDB_Jump), .CDB_Target(CDB_Target),
        .Query_Tag(Query_Tag), .Query_Done(Query_Done), .Query_Value(Query_Value),
        .ROB_Ready(ROB_Ready), .ROB_Addr(ROB_Addr), .ROB_Value(ROB_Value), .ROB_Tag(ROB_Tag),
        .Store_Commit(Store_Commit), .Store_Tag(Store_Tag),
        .clr(clr), .New_PC(New_PC)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of retirement events in program order; unused fields are zero.
    typedef struct packed {
        logic        rr;
        logic [4:0]  addr;
        logic [31:0] val;
        logic [3:0]  tag;
        logic        st;
        logic [3:0]  st_tag;
        logic        fl;
        logic [31:0] pc;
    } ev_t;

    ev_t sb[$];
    ev_t got, want;

    task automatic push_ev(input logic rr, input logic [4:0] addr, input logic [31:0] val,
                           input logic [3:0] tag, input logic st, input logic [3:0] st_tag,
                           input logic fl, input logic [31:0] pc);
        ev_t e;
        e.rr     = rr;
        e.addr   = rr ? addr : 5'd0;
        e.val    = rr ? val : 32'd0;
        e.tag    = rr ? tag : 4'd0;
        e.st     = st;
        e.st_tag = st ? st_tag : 4'd0;
        e.fl     = fl;
        e.pc     = fl ? pc : 32'd0;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst && (ROB_Ready || Store_Commit || clr)) begin
            got.rr     = ROB_Ready;
            got.addr   = ROB_Ready ? ROB_Addr : 5'd0;
            got.val    = ROB_Ready ? ROB_Value : 32'd0;
            got.tag    = ROB_Ready ? ROB_Tag : 4'd0;
            got.st     = Store_Commit;
            got.st_tag = Store_Commit ? Store_Tag : 4'd0;
            got.fl     = clr;
            got.pc     = clr ? New_PC : 32'd0;
            if (sb.size() == 0) begin
                check("unexpected_pulse", got, 128'd0);
            end else begin
                want = sb.pop_front();
                check("commit_event", got, want);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Issue_Ready = 1'b0;
        CDB_Ready   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic do_issue(input logic [1:0] ty, input logic [31:0] rd);
        Issue_Ready = 1'b1;
        Issue_Type  = ty;
        Issue_Rd    = rd;
        tick();
        Issue_Ready = 1'b0;
    endtask

    task automatic do_cdb(input logic [3:0] tag, input logic [31:0] val,
                          input logic jump, input logic [31:0] target);
        CDB_Ready  = 1'b1;
        CDB_Tag    = tag;
        CDB_Value  = val;
        CDB_Jump   = jump;
        CDB_Target = target;
        tick();
        CDB_Ready = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check(name, sb.size(), 0);
        tick();
        tick();
    endtask

    typedef struct {
        logic        iss;
        logic [1:0]  ty;
        logic [31:0] rd;
        logic        cdb;
        logic [3:0]  ctag;
        logic [31:0] cval;
        logic [3:0]  qtag;
        logic [3:0]  e_tail;
        logic        e_succ;
        logic        e_rr;
        logic [4:0]  e_addr;
        logic [31:0] e_val;
        logic [3:0]  e_tag;
        logic        e_qdone;
        logic [31:0] e_qval;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rdy = 1'b1;
        Issue_Type = 2'd0; Issue_Rd = '0;
        CDB_Tag = '0; CDB_Value = '0; CDB_Jump = 1'b0; CDB_Target = '0;
        Query_Tag = '0;
        rst = 1'b0;
        idle();
        tick();
        tick();
        check("rst_success", success, 1);
        check("rst_tail", ROB_Tail, 0);
        check("rst_pulses", {ROB_Ready, Store_Commit, clr}, 0);
        check("rst_data", {ROB_Addr, ROB_Value, ROB_Tag, Store_Tag, New_PC}, 0);
        check("rst_query", Query_Done, 0);
        rst = 1'b1;

        // Out-of-order completion (tags 2,0,1) retiring in program order.
        vecs[0] = '{1'b1, 2'd0, 32'd1, 1'b0, 4'd0, 32'h00, 4'd0, 4'd1, 1'b1, 1'b0, 5'd0, 32'h00, 4'd0, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 2'd0, 32'd2, 1'b0, 4'd0, 32'h00, 4'd0, 4'd2, 1'b1, 1'b0, 5'd0, 32'h00, 4'd0, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 2'd0, 32'd3, 1'b0, 4'd0, 32'h00, 4'd0, 4'd3, 1'b1, 1'b0, 5'd0, 32'h00, 4'd0, 1'b0, 32'h00};
        vecs[3] = '{1'b0, 2'd0, 32'd0, 1'b1, 4'd2, 32'h22, 4'd2, 4'd3, 1'b1, 1'b0, 5'd0, 32'h00, 4'd0, 1'b1, 32'h22};
        vecs[4] = '{1'b0, 2'd0, 32'd0, 1'b1, 4'd0, 32'h00, 4'd1, 4'd3, 1'b1, 1'b0, 5'd0, 32'h00, 4'd0, 1'b0, 32'h00};
        vecs[5] = '{1'b0, 2'd0, 32'd0, 1'b1, 4'd1, 32'h11, 4'd0, 4'd3, 1'b1, 1'b1, 5'd1, 32'h00, 4'd0, 1'b0, 32'h00};
        vecs[6] = '{1'b0, 2'd0, 32'd0, 1'b0, 4'd0, 32'h00, 4'd2, 4'd3, 1'b1, 1'b1, 5'd2, 32'h11, 4'd1, 1'b1, 32'h22};
        vecs[7] = '{1'b0, 2'd0, 32'd0, 1'b0, 4'd0, 32'h00, 4'd1, 4'd3, 1'b1, 1'b1, 5'd3, 32'h22, 4'd2, 1'b0, 32'h00};
        vecs[8] = '{1'b0, 2'd0, 32'd0, 1'b0, 4'd0, 32'h00, 4'd2, 4'd3, 1'b1, 1'b0, 5'd0, 32'h00, 4'd0, 1'b0, 32'h00};
        push_ev(1'b1, 5'd1, 32'h00, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0);
        push_ev(1'b1, 5'd2, 32'h11, 4'd1, 1'b0, 4'd0, 1'b0, 32'd0);
        push_ev(1'b1, 5'd3, 32'h22, 4'd2, 1'b0, 4'd0, 1'b0, 32'd0);
        for (int i = 0; i < 9; i++) begin
            Issue_Ready = vecs[i].iss;
            Issue_Type  = vecs[i].ty;
            Issue_Rd    = vecs[i].rd;
            CDB_Ready   = vecs[i].cdb;
            CDB_Tag     = vecs[i].ctag;
            CDB_Value   = vecs[i].cval;
            Query_Tag   = vecs[i].qtag;
            tick();
            idle();
            check("vec_tail", ROB_Tail, vecs[i].e_tail);
            check("vec_success", success, vecs[i].e_succ);
            check("vec_rob_ready", ROB_Ready, vecs[i].e_rr);
            if (vecs[i].e_rr)
                check("vec_commit_data", {ROB_Addr, ROB_Value, ROB_Tag},
                      {vecs[i].e_addr, vecs[i].e_val, vecs[i].e_tag});
            check("vec_query_done", Query_Done, vecs[i].e_qdone);
            if (vecs[i].e_qdone) check("vec_query_value", Query_Value, vecs[i].e_qval);
        end
        wait_drain("inorder_drain");

        // Fill to capacity, refuse the 17th, refuse issue even on a freeing commit.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            check("fill_tail", ROB_Tail, i);
            check("fill_success", success, 1);
            do_issue(2'd0, i + 1);
        end
        check("full_success", success, 0);
        check("full_tail_wrap", ROB_Tail, 0);
        do_issue(2'd0, 32'd31);
        check("refuse_17th_tail", ROB_Tail, 0);
        check("refuse_17th_success", success, 0);
        push_ev(1'b1, 5'd1, 32'h5A, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0);
        do_cdb(4'd0, 32'h5A, 1'b0, 32'd0);
        do_issue(2'd0, 32'd20);
        check("full_commit_refuse_success", success, 1);
        check("full_commit_refuse_tail", ROB_Tail, 0);
        do_issue(2'd0, 32'd21);
        check("after_free_tail", ROB_Tail, 1);
        check("after_free_success", success, 0);

        // Reset while tag 1 is ready to retire: no pulse, everything discarded.
        CDB_Ready = 1'b1; CDB_Tag = 4'd1; CDB_Value = 32'h66;
        tick();
        CDB_Ready = 1'b0;
        rst = 1'b0;
        tick();
        check("midreset_no_commit", ROB_Ready, 0);
        rst = 1'b1;
        tick();
        check("midreset_tail", ROB_Tail, 0);
        check("midreset_success", success, 1);
        check("midreset_sb_empty", sb.size(), 0);
        do_cdb(4'd1, 32'h77, 1'b0, 32'd0);
        Query_Tag = 4'd1;
        #1;
        check("cdb_to_invalid_ignored", Query_Done, 0);
        tick();
        tick();

        // Mispredicted branch with three completed younger entries.
        do_reset();
        do_issue(2'b10, 32'h0000_1001);
        do_issue(2'd0, 32'd2);
        do_issue(2'd0, 32'd3);
        do_issue(2'd0, 32'd4);
        do_cdb(4'd1, 32'h11, 1'b0, 32'd0);
        do_cdb(4'd2, 32'h22, 1'b0, 32'd0);
        do_cdb(4'd3, 32'h33, 1'b0, 32'd0);
        push_ev(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1, 32'h1010);
        do_cdb(4'd0, 32'h0, 1'b0, 32'h1010);
        Issue_Ready = 1'b1; Issue_Type = 2'd0; Issue_Rd = 32'd9;
        CDB_Ready = 1'b1; CDB_Tag = 4'd1;
        tick();
        idle();
        check("flush_clr", clr, 1);
        check("flush_new_pc", New_PC, 32'h1010);
        check("flush_tail", ROB_Tail, 0);
        check("flush_success", success, 1);
        Query_Tag = 4'd1;
        #1;
        check("flush_query_cleared", Query_Done, 0);
        tick();
        check("flush_pulse_one_cycle", clr, 0);
        do_issue(2'd0, 32'd5);
        check("post_flush_tag0", ROB_Tail, 1);
        push_ev(1'b1, 5'd5, 32'h55, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0);
        do_cdb(4'd0, 32'h55, 1'b0, 32'd0);
        wait_drain("flush_drain");

        // Correctly predicted not-taken branch, then the younger register write.
        do_reset();
        do_issue(2'b10, 32'h0000_2000);
        push_ev(1'b1, 5'd7, 32'h77, 4'd1, 1'b0, 4'd0, 1'b0, 32'd0);
        do_issue(2'd0, 32'd7);
        do_cdb(4'd1, 32'h77, 1'b0, 32'd0);
        do_cdb(4'd0, 32'h0, 1'b0, 32'h3000);
        tick();
        check("good_branch_no_clr", clr, 0);
        check("good_branch_no_write", ROB_Ready, 0);
        check("good_branch_tail", ROB_Tail, 2);
        tick();
        check("good_branch_next_commit", {ROB_Ready, ROB_Tag}, {1'b1, 4'd1});
        wait_drain("branch_ok_drain");

        // JALR: link write and redirect in the same cycle.
        do_reset();
        do_issue(2'b11, 32'd1);
        push_ev(1'b1, 5'd1, 32'h104, 4'd0, 1'b0, 4'd0, 1'b1, 32'h200);
        do_cdb(4'd0, 32'h104, 1'b1, 32'h200);
        tick();
        check("jalr_pulses", {ROB_Ready, clr}, 2'b11);
        check("jalr_data", {ROB_Addr, ROB_Value, New_PC}, {5'd1, 32'h104, 32'h200});
        wait_drain("jalr_drain");

        // Store between register writes, with a three-cycle stall mid-sequence.
        do_reset();
        push_ev(1'b1, 5'd10, 32'hA0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0);
        do_issue(2'd0, 32'd10);
        push_ev(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 4'd1, 1'b0, 32'd0);
        do_issue(2'b01, 32'hDEAD);
        push_ev(1'b1, 5'd11, 32'hB0, 4'd2, 1'b0, 4'd0, 1'b0, 32'd0);
        do_issue(2'd0, 32'd11);
        do_cdb(4'd0, 32'hA0, 1'b0, 32'd0);
        do_cdb(4'd1, 32'h0, 1'b0, 32'd0);
        do_cdb(4'd2, 32'hB0, 1'b0, 32'd0);
        check("store_commit", {Store_Commit, Store_Tag}, {1'b1, 4'd1});
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Issue_Ready = 1'b1; Issue_Type = 2'd0; Issue_Rd = 32'd12;
            tick();
            check("stall_no_pulse", {ROB_Ready, Store_Commit, clr}, 0);
            check("stall_tail", ROB_Tail, 3);
        end
        Issue_Ready = 1'b0;
        rdy = 1'b1;
        tick();
        check("resume_commit", {ROB_Ready, ROB_Addr, ROB_Tag}, {1'b1, 5'd11, 4'd2});
        wait_drain("store_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
